// File: rtl/chunked_addsub_pkg.sv
// Shared types and elaboration helpers for the chunked adder/subtractor.
package chunked_addsub_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // Index width; never below one bit so a single-chunk build still has a register.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

  function automatic int unsigned nchunk(input int unsigned width, input int unsigned chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/chunked_addsub_chunk_adder.sv
// CHUNK-bit ripple adder; also exposes the carry into its top bit for overflow detection.
module chunked_addsub_chunk_adder #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : gen_bit
    chunked_addsub_full_adder u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (c[i]),
      .s   (s[i]),
      .cout(c[i+1])
    );
  end

  assign cout  = c[CHUNK];
  assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/chunked_addsub_full_adder.sv
// One-bit full adder, the cell of the chunk ripple chain.
module chunked_addsub_full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/chunked_addsub.sv
// Multi-cycle WIDTH-bit add/sub, CHUNK bits per clock, valid/ready on both sides.
module chunked_addsub
  import chunked_addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int unsigned IDX_W  = clog2(NCHUNK);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  if (CHUNK == 0 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : gen_bad_params
    $error("chunked_addsub: WIDTH must be a nonzero multiple of CHUNK");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;

  logic [CHUNK-1:0] a_chunk, b_chunk, s_chunk;
  logic             c_out, c_msb;

  assign a_chunk = a_q[idx_q*CHUNK +: CHUNK];
  assign b_chunk = b_q[idx_q*CHUNK +: CHUNK];

  chunked_addsub_chunk_adder #(
    .CHUNK(CHUNK)
  ) u_chunk_adder (
    .a    (a_chunk),
    .b    (b_chunk),
    .cin  (carry_q),
    .s    (s_chunk),
    .cout (c_out),
    .c_msb(c_msb)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          // Subtraction is x + ~y + 1: invert here, seed the carry with sub.
          a_d     = x;
          b_d     = y ^ {WIDTH{sub}};
          carry_d = sub;
          idx_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        sum_d[idx_q*CHUNK +: CHUNK] = s_chunk;
        carry_d = c_out;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          cout_d  = c_out;
          ovf_d   = c_msb ^ c_out;
          zero_d  = (sum_d == '0);
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_chunked_addsub.sv
// Bench for chunked_addsub: directed 8/2 cases plus random sweeps at 16/16 and 16/1.
module tb_chunked_addsub;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 8-bit, 2-bit chunks
  logic       iv8, ir8, ov8, or8, sub8, c8, o8, z8;
  logic [7:0] x8, y8, s8;
  // 16-bit single-cycle (w) and bit-serial (n)
  logic        iv_w, ir_w, ov_w, or_w, c_w, o_w, z_w;
  logic        iv_n, ir_n, ov_n, or_n, c_n, o_n, z_n;
  logic        sub16;
  logic [15:0] x16, y16, s_w, s_n;

  int n_cmp = 0;
  int n_bad = 0;

  chunked_addsub #(.WIDTH(8), .CHUNK(2)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .x(x8), .y(y8), .sub(sub8),
    .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(c8), .ovf(o8), .zero(z8)
  );

  chunked_addsub #(.WIDTH(16), .CHUNK(16)) u_dut_w (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_w), .in_ready(ir_w), .x(x16), .y(y16), .sub(sub16),
    .out_valid(ov_w), .out_ready(or_w), .sum(s_w), .cout(c_w), .ovf(o_w), .zero(z_w)
  );

  chunked_addsub #(.WIDTH(16), .CHUNK(1)) u_dut_n (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_n), .in_ready(ir_n), .x(x16), .y(y16), .sub(sub16),
    .out_valid(ov_n), .out_ready(or_n), .sum(s_n), .cout(c_n), .ovf(o_n), .zero(z_n)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views of the operands.
  function automatic void model(input int w, input logic [15:0] a, input logic [15:0] b,
                                input logic s, output logic [15:0] r, output logic [2:0] f);
    longint m, ua, ub, sa, sb, u, sr;
    logic c, o;
    m  = longint'(1) << w;
    ua = longint'(a) & (m - 1);
    ub = longint'(b) & (m - 1);
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    if (s) begin
      u = ua - ub; sr = sa - sb; c = (ua >= ub);
    end else begin
      u = ua + ub; sr = sa + sb; c = (u >= m);
    end
    r = 16'(u & (m - 1));
    o = (sr >= m / 2) || (sr < -(m / 2));
    f = {c, o, (r == 16'h0)};
  endfunction

  task automatic wait_ov8(output int lat);
    lat = 0;
    while (!ov8 && lat < 50) begin
      step();
      lat++;
    end
  endtask

  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic s,
                     input logic [7:0] es, input logic ec, input logic eo, input logic ez);
    int lat;
    iv8 = 1'b1; x8 = a; y8 = b; sub8 = s;
    check({tag, "_in_ready"}, 32'(ir8), 32'd1);
    step();
    // Operands change after acceptance and must be ignored.
    iv8 = 1'b0; x8 = 8'($urandom); y8 = 8'($urandom); sub8 = ~s;
    wait_ov8(lat);
    check({tag, "_latency"}, 32'(lat), 32'd4);
    check({tag, "_sum"}, 32'(s8), 32'(es));
    check({tag, "_flags"}, 32'({c8, o8, z8}), 32'({ec, eo, ez}));
    or8 = 1'b1;
    step();
    or8 = 1'b0;
    check({tag, "_idle"}, 32'({ir8, ov8}), 32'b10);
  endtask

  task automatic sweep(input bit narrow, input int n_ops);
    logic [15:0] xa, ya, es;
    logic [2:0]  ef;
    logic        sa, v;
    int          lat;
    for (int i = 0; i < n_ops; i++) begin
      repeat ($urandom_range(0, 2)) step();
      xa = 16'($urandom); ya = 16'($urandom); sa = 1'($urandom_range(0, 1));
      model(16, xa, ya, sa, es, ef);
      x16 = xa; y16 = ya; sub16 = sa;
      if (narrow) iv_n = 1'b1; else iv_w = 1'b1;
      step();
      iv_n = 1'b0; iv_w = 1'b0;
      x16 = 16'($urandom); y16 = 16'($urandom);
      lat = 0;
      v = narrow ? ov_n : ov_w;
      while (!v && lat < 60) begin
        step();
        lat++;
        v = narrow ? ov_n : ov_w;
      end
      check(narrow ? "sweep_n_latency" : "sweep_w_latency", 32'(lat), narrow ? 32'd16 : 32'd1);
      repeat ($urandom_range(0, 2)) step();
      check(narrow ? "sweep_n_sum" : "sweep_w_sum", 32'(narrow ? s_n : s_w), 32'(es));
      check(narrow ? "sweep_n_flags" : "sweep_w_flags",
            32'(narrow ? {c_n, o_n, z_n} : {c_w, o_w, z_w}), 32'(ef));
      if (narrow) or_n = 1'b1; else or_w = 1'b1;
      step();
      or_n = 1'b0; or_w = 1'b0;
    end
  endtask

  initial begin
    int lat;
    rst_n = 1'b0;
    iv8 = 0; or8 = 0; sub8 = 0; x8 = 0; y8 = 0;
    iv_w = 0; or_w = 0; iv_n = 0; or_n = 0; sub16 = 0; x16 = 0; y16 = 0;
    repeat (2) step();
    check("reset_hs8", 32'({ir8, ov8}), 32'b10);
    check("reset_out8", 32'({s8, c8, o8, z8}), 32'h0);
    check("reset_hs16", 32'({ir_w, ov_w, ir_n, ov_n}), 32'b1010);
    rst_n = 1'b1;
    step();

    op8("add_3c_05", 8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0, 1'b0);
    op8("sub_05_07", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);
    op8("sub_80_80", 8'h80, 8'h80, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
    op8("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
    op8("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    op8("sub_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);

    // Backpressure: DONE held while a new operation is offered.
    iv8 = 1'b1; x8 = 8'h11; y8 = 8'h22; sub8 = 1'b0;
    step();
    x8 = 8'h40; y8 = 8'h03; sub8 = 1'b1;
    wait_ov8(lat);
    check("bp_latency", 32'(lat), 32'd4);
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_hold", 32'({ov8, ir8, s8, c8, o8, z8}), 32'({2'b10, 8'h33, 3'b000}));
    end
    or8 = 1'b1;
    step();
    or8 = 1'b0;
    check("bp_ready_after", 32'({ir8, ov8}), 32'b10);
    step();
    iv8 = 1'b0;
    wait_ov8(lat);
    check("bp_new_latency", 32'(lat), 32'd4);
    check("bp_new_result", 32'({s8, c8, o8, z8}), 32'({8'h3D, 3'b100}));
    or8 = 1'b1;
    step();
    or8 = 1'b0;

    // Reset during the second chunk discards the partial sum.
    iv8 = 1'b1; x8 = 8'h55; y8 = 8'h11; sub8 = 1'b0;
    step();
    iv8 = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    check("rst_mid_hs", 32'({ir8, ov8}), 32'b10);
    check("rst_mid_sum", 32'(s8), 32'h0);
    rst_n = 1'b1;
    step();
    op8("post_rst", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0);

    sweep(1'b0, 1000);
    sweep(1'b1, 1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/chunked_addsub.md
Name: chunked_addsub

Overview:
- Parametrised multi-cycle adder/subtractor; successor to the fixed 4-bit combinational add/sub.
- Processes WIDTH-bit two's-complement operands CHUNK bits per clock, holding the inter-chunk carry in a register.
- Uses valid/ready handshakes on both input and output, so it sits directly in datapath pipelines.
- Reports carry/no-borrow, signed overflow and zero flags.

Parameters:
- WIDTH, 16, operand and result width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits processed per cycle; 1 ≤ CHUNK ≤ WIDTH; CHUNK = WIDTH gives single-cycle operation.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  operands and sub are valid.
- in_ready  out  1  block can accept an operation; high only in IDLE.
- x  in  WIDTH  operand A.
- y  in  WIDTH  operand B.
- sub  in  1  0 computes x+y; 1 computes x-y.
- out_valid  out  1  result and flags are valid.
- out_ready  in  1  consumer takes the result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  carry out of MSB; for sub=1, 1 means no borrow (x ≥ y unsigned).
- ovf  out  1  signed overflow = carry into MSB XOR carry out of MSB.
- zero  out  1  sum == 0.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-low, rst_n.
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE; in_ready=1; out_valid=0.
  - sum, cout, ovf, zero, chunk index and carry register all go to 0.
  - Reset wins over every other event, including mid-RUN and mid-DONE; a partial result is discarded.
- NCHUNK = WIDTH/CHUNK.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: latch x, latch y XOR {WIDTH{sub}}, carry = sub, index = 0; go to RUN.
  - x, y and sub are sampled only at acceptance; later changes are ignored.
- RUN:
  - in_ready=0.
  - Each cycle adds latched chunk [index*CHUNK +: CHUNK] with the carry register, writes that slice of sum, updates carry, and increments index.
  - On the last chunk (index = NCHUNK-1), also record the carry into the MSB for ovf; go to DONE.
- DONE:
  - out_valid=1; sum, cout, ovf and zero are held stable.
  - On out_ready=1 go to IDLE; in_ready=1 the following cycle (no same-cycle turnaround).
  - in_valid is ignored while out_valid=1.
- Latency: out_valid rises exactly NCHUNK cycles after the acceptance edge; throughput is one operation per NCHUNK+2 cycles with out_ready tied high.
- Flags:
  - All flags are registered and updated only on the last chunk.
  - zero is evaluated on the full final sum.
  - While not in DONE, outputs hold the previous result (0 after reset); consumers rely only on out_valid.
- Arithmetic: pure modulo 2^WIDTH; there is no saturation. x-y is computed as x + ~y + 1.
- Edge cases:
  - out_ready high while out_valid=0 has no effect.
  - in_valid held high continuously: a new operation is accepted each time the block is in IDLE.

Decomposition:
- Shared package: state enum {IDLE, RUN, DONE}; function clog2 for the index width; localparam NCHUNK helper.
- Sub-module chunk_adder: combinational CHUNK-bit ripple chain built from full_adder instances. Outputs are the CHUNK-bit sum, the carry out, and the carry into the top bit (for ovf).
- An elaboration-time check rejects WIDTH % CHUNK ≠ 0.

Test Plan:
- Add (WIDTH=8, CHUNK=2): x=8'h3C, y=8'h05, sub=0 → sum=8'h41, cout=0, ovf=0, zero=0; out_valid exactly 4 cycles after acceptance.
- Subtract with borrow: x=8'h05, y=8'h07, sub=1 → sum=8'hFE, cout=0, ovf=0. Then x=8'h80, y=8'h80, sub=1 → sum=8'h00, cout=1, zero=1.
- Overflow and wrap:
  - 8'h7F+8'h01 → 8'h80, ovf=1, cout=0.
  - 8'hFF+8'h01 → 8'h00, cout=1, ovf=0, zero=1.
  - 8'h80-8'h01 → 8'h7F, ovf=1, cout=1.
- Backpressure: hold out_ready=0 for 3 cycles in DONE while driving in_valid=1 with new operands → sum and flags stable, in_ready=0, new operands not accepted. After out_ready pulse → in_ready=1 next cycle, and the new operation is accepted and correct.
- Reset mid-RUN: assert rst_n=0 during the 2nd chunk → next edge out_valid=0, in_ready=1, sum=0. After release, 8'h10+8'h20 → 8'h30 with normal latency.
- Parameter sweep: CHUNK=WIDTH=16 (latency 1) and CHUNK=1, WIDTH=16 (latency 16) against a random reference model, 1000 operations each with random valid/ready gaps.
